bin_to_bcd_8: RTL and testbench
===============================

# bin_to_bcd_8

Sequential binary-to-BCD converter that produces the 32-bit, 8-digit packed-BCD word driving the eight-digit seven-segment decoder. It converts an unsigned binary count (frame counter, pixel-clock measurement, debug register) into decimal digits using an iterative shift-and-add-3 (double-dabble) algorithm, one bit per clock. It holds the last result stable so the display never shows intermediate values.

## Interface
- BIN_W, 27, width of binary input; 27 bits covers 0..99_999_999.
- DIGITS, 8, number of BCD digits; output width is 4*DIGITS.
- iCLK  in  1  system clock; all logic on the rising edge.
- iRST_N  in  1  reset, asynchronous, active-low.
- iSTART  in  1  conversion request; sampled only while idle.
- iBIN  in  BIN_W  unsigned binary value; captured on the accepting edge.
- oBCD  out  4*DIGITS  packed BCD result; digit 0 in [3:0], digit 7 in [31:28]; connects directly to the decoder's iDIG.
- oBUSY  out  1  high while a conversion is in progress.
- oDONE  out  1  one-cycle pulse when oBCD/oOVF are updated.
- oOVF  out  1  input exceeded 10^DIGITS-1; result saturated.

## Operation
- Reset values: oBCD=0, oBUSY=0, oDONE=0, oOVF=0, FSM in IDLE, shift counter 0.
- The FSM has two states: IDLE and SHIFT.
- IDLE: if iSTART=1, capture iBIN into the shift register and clear the BCD accumulator (4*DIGITS bits). Compute the overflow flag as iBIN > 10^DIGITS-1. Load counter = BIN_W-1 and go to SHIFT. If iSTART=0, stay in IDLE.
- SHIFT: each cycle, every accumulator nibble ≥5 gets +3. Then the concatenation {accumulator, binary} shifts left by 1.
  - Counter decrements each cycle.
  - On the cycle with counter=0, go to IDLE and write the final accumulator to oBCD. If the overflow flag is set, write 0x99999999 instead (all nines for DIGITS). Update oOVF from the flag and assert oDONE for exactly one cycle.
- oBCD and oOVF change only on the completion edge. They hold otherwise, including throughout SHIFT.
- iSTART during SHIFT is ignored. There is no queueing, and the request is not remembered.
- iSTART high in the cycle oDONE is high is accepted, because the FSM is already in IDLE. This allows back-to-back conversions.
- iSTART held high continuously gives repeated conversions every BIN_W+1 cycles.
- Overflow conversions take the same number of cycles as normal ones, so latency is uniform.
- Reset asserted mid-conversion aborts immediately and all outputs take their reset values. Conversion restarts only on a new iSTART after reset is released.
- Width rule: 4*DIGITS-bit accumulator. The intermediate nibble after add-3 never exceeds 4'b1100, so no carry leaves a nibble.

## Timing
- Let iSTART be sampled at edge k. Then oBUSY=1 after edge k through edge k+BIN_W.
- At edge k+BIN_W: oBUSY=0, oDONE=1, oBCD/oOVF take the new values.
- Latency start→result is BIN_W cycles (27 at defaults).
- oDONE falls after edge k+BIN_W+1 unless a new conversion completes then (impossible for BIN_W>1).
- All outputs are registered, with no combinational path from inputs to outputs.

## Structure
- Shared package (bcd_pkg) holds:
  - DIGITS and BIN_W defaults
  - BCD_MAX = 10^DIGITS-1
  - BCD_SAT constant (all-nines word)
  - the state enum {IDLE, SHIFT}
- One natural sub-module: bcd_add3, a combinational 4-bit nibble correction (in≥5 ? in+3 : in). It is instantiated DIGITS times via generate.
- Counter width is $clog2(BIN_W).

## Test plan
- Reset, then iBIN=0 with a 1-cycle iSTART: oBUSY high 27 cycles, oDONE pulse at edge k+27, oBCD=0x00000000, oOVF=0.
- iBIN=12_345_678 → oBCD=0x12345678, oOVF=0. iBIN=99_999_999 → 0x99999999, oOVF=0.
- iBIN=100_000_000 and iBIN=2^27-1 → oBCD=0x99999999, oOVF=1, same 27-cycle latency. A following iBIN=5 → 0x00000005, oOVF=0.
- iSTART pulses at k+3 and k+20 during a conversion of 42: ignored, single oDONE, oBCD=0x00000042. oBCD keeps its previous value until k+27.
- iSTART held high with iBIN stepping 7, 8, 9: results 0x7, 0x8, 0x9 on consecutive oDONE pulses spaced 28 cycles apart.
- iRST_N dropped at k+10 of a conversion: oBCD, oBUSY, oDONE, oOVF go to 0 asynchronously. No oDONE after release until a new iSTART.

Source files
------------

// File: rtl/bcd_pkg.sv
// bcd_pkg: shared definitions for the bin_to_bcd_8 converter.
//   BCD_DIGITS / BCD_BIN_W : default digit count and binary input width
//   BCD_MAX                : largest value representable in BCD_DIGITS digits
//   BCD_SAT                : all-nines word used when the input overflows
//   state_t                : converter FSM states
package bcd_pkg;

   localparam int unsigned BCD_DIGITS = 8;
   localparam int unsigned BCD_BIN_W  = 27;

   // 10**n computed at elaboration; 64 bits covers any practical digit count.
   function automatic logic [63:0] pow10(input int unsigned n);
      logic [63:0] r;
      r = 64'd1;
      for (int unsigned i = 0; i < n; i++) begin
         r = r * 64'd10;
      end
      return r;
   endfunction

   localparam logic [63:0]               BCD_MAX = pow10(BCD_DIGITS) - 64'd1;
   localparam logic [4*BCD_DIGITS-1:0]   BCD_SAT = {BCD_DIGITS{4'h9}};

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

endpackage

// File: rtl/bin_to_bcd_8_add3.sv
// bcd_add3: double-dabble nibble correction.
//   iNIB : accumulator nibble before the shift
//   oNIB : iNIB + 3 when iNIB >= 5, otherwise iNIB unchanged
module bcd_add3 (
   input  logic [3:0] iNIB,
   output logic [3:0] oNIB
);

   always_comb begin
      oNIB = (iNIB >= 4'd5) ? iNIB + 4'd3 : iNIB;
   end

endmodule

// File: rtl/bin_to_bcd_8.sv
// bin_to_bcd_8: sequential shift-and-add-3 binary to packed-BCD converter.
// One input bit is consumed per clock; the result registers change only on
// the completion edge so a downstream display never sees partial values.
//   iCLK   : clock, rising edge
//   iRST_N : asynchronous active-low reset
//   iSTART : conversion request, sampled only while idle
//   iBIN   : unsigned binary value, captured on the accepting edge
//   oBCD   : packed BCD result, digit 0 in [3:0]
//   oBUSY  : high while a conversion is running
//   oDONE  : one-cycle pulse when oBCD/oOVF update
//   oOVF   : input exceeded 10**DIGITS-1, oBCD saturated to all nines
module bin_to_bcd_8
   import bcd_pkg::*;
#(
   parameter int unsigned BIN_W  = BCD_BIN_W,
   parameter int unsigned DIGITS = BCD_DIGITS
) (
   input  logic                  iCLK,
   input  logic                  iRST_N,
   input  logic                  iSTART,
   input  logic [BIN_W-1:0]      iBIN,
   output logic [4*DIGITS-1:0]   oBCD,
   output logic                  oBUSY,
   output logic                  oDONE,
   output logic                  oOVF
);

   localparam int unsigned AW  = 4 * DIGITS;
   localparam int unsigned CW  = $clog2(BIN_W);
   localparam logic [63:0]    MAX = pow10(DIGITS) - 64'd1;
   localparam logic [AW-1:0]  SAT = {DIGITS{4'h9}};

   state_t                 state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [BIN_W-1:0]       bin_q, bin_d;
   logic [AW-1:0]          acc_q, acc_d;
   logic                   ovf_flag_q, ovf_flag_d;
   logic [AW-1:0]          bcd_q, bcd_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   ovf_q, ovf_d;

   logic [AW-1:0]          acc_corr;
   logic [AW+BIN_W-1:0]    shifted;

   for (genvar g = 0; g < DIGITS; g++) begin : g_add3
      bcd_add3 u_add3 (
         .iNIB (acc_q[4*g +: 4]),
         .oNIB (acc_corr[4*g +: 4])
      );
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bin_d      = bin_q;
      acc_d      = acc_q;
      ovf_flag_d = ovf_flag_q;
      bcd_d      = bcd_q;
      ovf_d      = ovf_q;
      done_d     = 1'b0;
      shifted    = {acc_corr, bin_q} << 1;

      case (state_q)
         IDLE: begin
            if (iSTART) begin
               bin_d      = iBIN;
               acc_d      = '0;
               ovf_flag_d = (64'(iBIN) > MAX);
               cnt_d      = CW'(BIN_W - 1);
               state_d    = SHIFT;
            end
         end
         SHIFT: begin
            acc_d = shifted[AW+BIN_W-1:BIN_W];
            bin_d = shifted[BIN_W-1:0];
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == '0) begin
               // Final bit: publish the freshly shifted accumulator, not acc_q.
               cnt_d   = '0;
               state_d = IDLE;
               bcd_d   = ovf_flag_q ? SAT : shifted[AW+BIN_W-1:BIN_W];
               ovf_d   = ovf_flag_q;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d == SHIFT);
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         bin_q      <= '0;
         acc_q      <= '0;
         ovf_flag_q <= 1'b0;
         bcd_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bin_q      <= bin_d;
         acc_q      <= acc_d;
         ovf_flag_q <= ovf_flag_d;
         bcd_q      <= bcd_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         ovf_q      <= ovf_d;
      end
   end

   assign oBCD  = bcd_q;
   assign oBUSY = busy_q;
   assign oDONE = done_q;
   assign oOVF  = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_8.sv
module tb_bin_to_bcd_8;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [26:0] bin;
   logic [31:0] bcd;
   logic        busy;
   logic        done;
   logic        ovf;

   int nchk = 0;
   int nerr = 0;
   int cyc  = 0;

   bin_to_bcd_8 #(.BIN_W(27), .DIGITS(8)) dut (
      .iCLK   (clk),
      .iRST_N (rst_n),
      .iSTART (start),
      .iBIN   (bin),
      .oBCD   (bcd),
      .oBUSY  (busy),
      .oDONE  (done),
      .oOVF   (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Reference: decimal digits by repeated division, saturating above 8 digits.
   function automatic logic [31:0] ref_bcd(input int unsigned v);
      logic [31:0] r;
      int unsigned x;
      r = '0;
      x = v;
      if (v > 32'd99_999_999) return 32'h9999_9999;
      for (int d = 0; d < 8; d++) begin
         r[4*d +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic logic ref_ovf(input int unsigned v);
      return v > 32'd99_999_999;
   endfunction

   // Issues a one-cycle request and waits (bounded) for the completion pulse.
   // lat = number of edges from the accepting edge to oDONE.
   task automatic run_conv(input logic [26:0] v, output int lat);
      @(posedge clk); #1;
      bin = v; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 0;
      while (!done && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0; start = 1'b0; bin = '0;
      repeat (3) @(posedge clk);
      #1;
      nchk++;
      if ({bcd, busy, done, ovf} !== 35'd0) begin
         nerr++;
         $display("FAIL reset_outputs: got bcd=%h busy=%b done=%b ovf=%b, want all 0", bcd, busy, done, ovf);
      end
      @(negedge clk); rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      nchk++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         nerr++;
         $display("FAIL idle_after_reset: got busy=%b done=%b, want 0 0", busy, done);
      end
   endtask

   task automatic test_zero_timing;
      int busy_bad;
      busy_bad = 0;
      @(posedge clk); #1;
      bin = 27'd0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 1; i <= 26; i++) begin
         if (busy !== 1'b1 || done !== 1'b0) busy_bad++;
         @(posedge clk); #1;
      end
      if (busy !== 1'b1 || done !== 1'b0) busy_bad++;
      nchk++;
      if (busy_bad != 0) begin
         nerr++;
         $display("FAIL zero_busy_window: %0d cycles with busy!=1 or done!=0, want 0", busy_bad);
      end
      @(posedge clk); #1;
      nchk++;
      if (busy !== 1'b0 || done !== 1'b1 || bcd !== 32'h0 || ovf !== 1'b0) begin
         nerr++;
         $display("FAIL zero_result_k27: got busy=%b done=%b bcd=%h ovf=%b, want 0 1 00000000 0", busy, done, bcd, ovf);
      end
      @(posedge clk); #1;
      nchk++;
      if (done !== 1'b0) begin
         nerr++;
         $display("FAIL zero_done_pulse: got done=%b at k+28, want 0", done);
      end
   endtask

   task automatic test_values;
      logic [26:0] vals [6];
      int lat;
      vals[0] = 27'd12_345_678;
      vals[1] = 27'd99_999_999;
      vals[2] = 27'd100_000_000;
      vals[3] = 27'h7FF_FFFF;
      vals[4] = 27'd5;
      vals[5] = 27'd9;
      foreach (vals[i]) begin
         run_conv(vals[i], lat);
         nchk++;
         if (lat != 27 || bcd !== ref_bcd(32'(vals[i])) || ovf !== ref_ovf(32'(vals[i]))) begin
            nerr++;
            $display("FAIL value_%0d: in=%0d got lat=%0d bcd=%h ovf=%b, want lat=27 bcd=%h ovf=%b",
                     i, vals[i], lat, bcd, ovf, ref_bcd(32'(vals[i])), ref_ovf(32'(vals[i])));
         end
      end
   endtask

   task automatic test_ignore_start;
      logic [31:0] prev;
      int hold_bad;
      int extra_done;
      prev = bcd;
      hold_bad = 0;
      extra_done = 0;
      @(posedge clk); #1;
      bin = 27'd42; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 1; i <= 26; i++) begin
         start = (i == 3 || i == 20);
         bin   = 27'd77;
         @(posedge clk); #1;
         start = 1'b0;
         if (done !== 1'b0 || bcd !== prev) hold_bad++;
      end
      @(posedge clk); #1;
      nchk++;
      if (hold_bad != 0) begin
         nerr++;
         $display("FAIL ignore_hold: %0d cycles with done!=0 or bcd!=%h, want 0", hold_bad, prev);
      end
      nchk++;
      if (done !== 1'b1 || bcd !== 32'h0000_0042 || ovf !== 1'b0) begin
         nerr++;
         $display("FAIL ignore_result: got done=%b bcd=%h ovf=%b, want 1 00000042 0", done, bcd, ovf);
      end
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (done === 1'b1 || busy === 1'b1) extra_done++;
      end
      nchk++;
      if (extra_done != 0) begin
         nerr++;
         $display("FAIL ignore_no_requeue: %0d cycles with done/busy after completion, want 0", extra_done);
      end
   endtask

   task automatic test_back_to_back;
      int t [3];
      int w;
      logic [26:0] seq [3];
      seq[0] = 27'd7; seq[1] = 27'd8; seq[2] = 27'd9;
      @(posedge clk); #1;
      bin = seq[0]; start = 1'b1;
      for (int n = 0; n < 3; n++) begin
         @(posedge clk); #1;
         w = 0;
         while (!done && w < 60) begin
            @(posedge clk); #1;
            w++;
         end
         t[n] = cyc;
         nchk++;
         if (done !== 1'b1 || bcd !== ref_bcd(32'(seq[n])) || ovf !== 1'b0) begin
            nerr++;
            $display("FAIL b2b_result_%0d: got done=%b bcd=%h ovf=%b, want 1 %h 0", n, done, bcd, ovf, ref_bcd(32'(seq[n])));
         end
         if (n < 2) bin = seq[n+1];
         else start = 1'b0;
      end
      nchk++;
      if (t[1] - t[0] != 28 || t[2] - t[1] != 28) begin
         nerr++;
         $display("FAIL b2b_spacing: got %0d and %0d cycles, want 28 and 28", t[1] - t[0], t[2] - t[1]);
      end
   endtask

   task automatic test_random;
      int lat;
      int unsigned v;
      for (int i = 0; i < 16; i++) begin
         case (i % 4)
            0: v = $urandom_range(32'd134_217_727, 32'd0);
            1: v = $urandom_range(32'd100_000_100, 32'd99_999_900);
            2: v = $urandom_range(32'd9_999, 32'd0);
            default: v = $urandom_range(32'd99_999_999, 32'd10_000_000);
         endcase
         run_conv(27'(v), lat);
         nchk++;
         if (lat != 27 || bcd !== ref_bcd(v) || ovf !== ref_ovf(v)) begin
            nerr++;
            $display("FAIL random_%0d: in=%0d got lat=%0d bcd=%h ovf=%b, want lat=27 bcd=%h ovf=%b",
                     i, v, lat, bcd, ovf, ref_bcd(v), ref_ovf(v));
         end
      end
   endtask

   task automatic test_reset_mid;
      int lat;
      int stray;
      stray = 0;
      run_conv(27'd31_415_926, lat);
      @(posedge clk); #1;
      bin = 27'd123; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      nchk++;
      if ({bcd, busy, done, ovf} !== 35'd0) begin
         nerr++;
         $display("FAIL reset_mid_async: got bcd=%h busy=%b done=%b ovf=%b, want all 0", bcd, busy, done, ovf);
      end
      @(negedge clk); rst_n = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (done !== 1'b0 || busy !== 1'b0) stray++;
      end
      nchk++;
      if (stray != 0) begin
         nerr++;
         $display("FAIL reset_mid_no_resume: %0d cycles with busy/done after release, want 0", stray);
      end
      run_conv(27'd5, lat);
      nchk++;
      if (lat != 27 || bcd !== 32'h0000_0005 || ovf !== 1'b0) begin
         nerr++;
         $display("FAIL reset_mid_restart: got lat=%0d bcd=%h ovf=%b, want 27 00000005 0", lat, bcd, ovf);
      end
   endtask

   initial begin
      test_reset;
      test_zero_timing;
      test_values;
      test_ignore_start;
      test_back_to_back;
      test_random;
      test_reset_mid;
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
